// File: rtl/rr_mux_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: requester count, index width,
// FSM state encoding and the rotating-index helper.
package rr_mux_arbiter_pkg;

    localparam int NUM_REQ = 4;
    localparam int IDX_W   = 2;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // Index of the requester after i, wrapping 3 -> 0.
    function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
        return i + 2'd1;
    endfunction

endpackage

// File: rtl/rr_next_pick.sv
// Combinational round-robin picker: first requester at or after ptr (mod NUM_REQ)
// whose req and mask bits are both set.
module rr_next_pick
    import rr_mux_arbiter_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    input  logic [NUM_REQ-1:0] mask,
    output logic               any,
    output logic [IDX_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot
);

    logic [NUM_REQ-1:0] hit;
    logic [IDX_W-1:0]   cand [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_scan
            assign cand[gi] = ptr + IDX_W'(gi);
            assign hit[gi]  = req[cand[gi]] & mask[cand[gi]];
        end
    endgenerate

    // Walk from the farthest slot down so the slot nearest ptr wins.
    always_comb begin
        any = 1'b0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (hit[k]) begin
                any = 1'b1;
                idx = cand[k];
            end
        end
    end

    assign onehot = any ? (NUM_REQ'(1) << idx) : '0;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sequencing a shared 4:1 mux; all outputs registered.
// Optional burst limit with forced rotation is enabled by defining RR_ARB_TIMEOUT_EN.
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int MAX_BURST = 8,
    parameter int CNT_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               address0,
    output logic               address1,
    output logic               valid,
    output logic               preempted
);

    generate
        if ((1 << CNT_W) < MAX_BURST || MAX_BURST < 1) begin : g_bad_burst_cfg
            $error("rr_mux_arbiter: CNT_W too narrow for MAX_BURST");
        end
    endgenerate

    state_e             state_reg, state_next;
    logic [NUM_REQ-1:0] grant_reg, grant_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic [IDX_W-1:0]   ptr_reg, ptr_next;
    logic               preempted_reg, preempted_next;

    logic [IDX_W-1:0]   pick_ptr;
    logic [NUM_REQ-1:0] pick_mask;
    logic               pick_any;
    logic [IDX_W-1:0]   pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;

    logic               req_hold;
    logic               expired;
    logic               rotate;

    // One picker serves both paths: from IDLE it scans from ptr over everyone,
    // from BUSY it scans from g+1 with the current holder masked out.
    assign pick_ptr  = (state_reg == ST_IDLE) ? ptr_reg : idx_inc(idx_reg);
    assign pick_mask = (state_reg == ST_IDLE) ? {NUM_REQ{1'b1}} : ~grant_reg;

    rr_next_pick u_pick (
        .req    (req),
        .ptr    (pick_ptr),
        .mask   (pick_mask),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    assign req_hold = |(req & grant_reg);

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

    logic [CNT_W-1:0] burst_cnt_reg, burst_cnt_next;

    assign expired = (burst_cnt_reg >= BURST_LAST) && (|(req & ~grant_reg));

    // Cleared on every new grant; saturates while nobody else is waiting.
    always_comb begin
        burst_cnt_next = burst_cnt_reg;
        if (state_reg == ST_IDLE) begin
            if (pick_any) burst_cnt_next = '0;
        end else if (rotate) begin
            burst_cnt_next = '0;
        end else if (burst_cnt_reg < BURST_LAST) begin
            burst_cnt_next = burst_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) burst_cnt_reg <= '0;
        else       burst_cnt_reg <= burst_cnt_next;
    end
`else
    assign expired = 1'b0;
`endif

    assign rotate = (state_reg == ST_BUSY) && (!req_hold || expired);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            grant_reg     <= '0;
            idx_reg       <= '0;
            ptr_reg       <= '0;
            preempted_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            idx_reg       <= idx_next;
            ptr_reg       <= ptr_next;
            preempted_reg <= preempted_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (pick_any) state_next = ST_BUSY;
            ST_BUSY: if (rotate && !pick_any) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // idx is left untouched when going idle so the mux select holds the last index.
    always_comb begin
        grant_next     = grant_reg;
        idx_next       = idx_reg;
        ptr_next       = ptr_reg;
        preempted_next = 1'b0;
        if (state_reg == ST_IDLE) begin
            if (pick_any) begin
                grant_next = pick_onehot;
                idx_next   = pick_idx;
            end
        end else if (rotate) begin
            ptr_next       = idx_inc(idx_reg);
            preempted_next = req_hold;
            grant_next     = pick_onehot;
            if (pick_any) idx_next = pick_idx;
        end
    end

    assign grant     = grant_reg;
    assign address0  = idx_reg[0];
    assign address1  = idx_reg[1];
    assign valid     = (state_reg == ST_BUSY);
    assign preempted = preempted_reg;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Randomized and directed bench for rr_mux_arbiter against an integer-level round-robin model.
module tb_rr_mux_arbiter;

    localparam int MAX_BURST = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic       address0, address1, valid, preempted;

    int checks = 0;
    int errors = 0;

    int m_cur;
    int m_ptr;
    int m_burst;
    int m_last;
    bit m_pre;

    always #5 clk = ~clk;

    rr_mux_arbiter #(.MAX_BURST(MAX_BURST), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .grant     (grant),
        .address0  (address0),
        .address1  (address1),
        .valid     (valid),
        .preempted (preempted)
    );

    task automatic model_reset();
        m_cur = -1; m_ptr = 0; m_burst = 0; m_last = 0; m_pre = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r);
        int  excl;
        bit  expire;
        logic [3:0] others;
        m_pre = 1'b0;
        excl  = -1;
        if (m_cur >= 0) begin
            expire = 1'b0;
            others = r;
            others[m_cur] = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
            expire = (m_burst >= MAX_BURST - 1) && (others != 4'b0000);
`endif
            if (r[m_cur] && !expire) begin
                if (m_burst < MAX_BURST - 1) m_burst++;
                return;
            end
            m_pre = r[m_cur];
            m_ptr = (m_cur + 1) % 4;
            excl  = m_cur;
            m_cur = -1;
        end
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (m_ptr + k) % 4;
            if (i != excl && r[i] && m_cur < 0) begin
                m_cur = i; m_last = i; m_burst = 0;
            end
        end
    endtask

    function automatic logic [7:0] exp_vec();
        logic [3:0] g;
        g = 4'b0000;
        if (m_cur >= 0) g[m_cur] = 1'b1;
        return {g, 2'(m_last), (m_cur >= 0), m_pre};
    endfunction

    function automatic logic [7:0] obs_vec();
        return {grant, address1, address0, valid, preempted};
    endfunction

    function automatic int grant_index(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic tick(input logic rst, input logic [3:0] r);
        reset = rst;
        req   = r;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(r);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 4'b1111);
        tick(1'b1, 4'b1111);
        checks++;
        if (obs_vec() !== 8'b0000_00_0_0) begin
            errors++;
            $display("FAIL reset {grant,a1,a0,valid,pre} got %b want %b", obs_vec(), 8'b0000_00_0_0);
        end
        $display("reset: grant=%b valid=%b", grant, valid);
    endtask

    task automatic test_rotation();
        logic [3:0] r;
        logic [9:0] seq_bits;
        int nseq, held, last;
        r = 4'b1111; seq_bits = '0; nseq = 0; held = 0; last = -1;
        for (int c = 0; c < 20 && nseq < 5; c++) begin
            tick(1'b0, r);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rotation cyc%0d got %b want %b", c, obs_vec(), exp_vec());
            end
            if (grant_index(grant) != last) begin
                last = grant_index(grant);
                seq_bits = {seq_bits[7:0], 2'(last)};
                nseq++;
                held = 1;
            end else begin
                held++;
            end
            r = 4'b1111;
            if (held == 2 && m_cur >= 0) r[m_cur] = 1'b0;
            $display("rotation cyc%0d: req=%b grant=%b addr=%b%b", c, req, grant, address1, address0);
        end
        checks++;
        if (nseq != 5 || seq_bits !== 10'b00_01_10_11_00) begin
            errors++;
            $display("FAIL rotation_order got n=%0d seq=%b want n=5 seq=%b", nseq, seq_bits, 10'b0001101100);
        end
    endtask

    task automatic test_single();
        tick(1'b1, 4'b0000);
        tick(1'b0, 4'b0100);
        checks++;
        if (obs_vec() !== 8'b0100_10_1_0) begin
            errors++;
            $display("FAIL single_grant got %b want %b", obs_vec(), 8'b0100_10_1_0);
        end
        tick(1'b0, 4'b0000);
        checks++;
        if (obs_vec() !== 8'b0000_10_0_0) begin
            errors++;
            $display("FAIL single_release got %b want %b", obs_vec(), 8'b0000_10_0_0);
        end
        $display("single: grant=%b addr=%b%b valid=%b", grant, address1, address0, valid);
    endtask

    task automatic test_wrap();
        logic [7:0] want [3];
        logic [3:0] stim [3];
        want = '{8'b1000_11_1_0, 8'b1000_11_1_0, 8'b0001_00_1_0};
        stim = '{4'b1000, 4'b1011, 4'b0011};
        tick(1'b1, 4'b0000);
        for (int c = 0; c < 3; c++) begin
            tick(1'b0, stim[c]);
            checks++;
            if (obs_vec() !== want[c]) begin
                errors++;
                $display("FAIL wrap cyc%0d got %b want %b", c, obs_vec(), want[c]);
            end
            $display("wrap cyc%0d: req=%b grant=%b valid=%b", c, req, grant, valid);
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 4'b0000);
        tick(1'b0, 4'b0100);
        tick(1'b0, 4'b0100);
        tick(1'b1, 4'b0100);
        checks++;
        if (obs_vec() !== 8'b0000_00_0_0) begin
            errors++;
            $display("FAIL reset_mid got %b want %b", obs_vec(), 8'b0000_00_0_0);
        end
        tick(1'b0, 4'b0110);
        checks++;
        if (obs_vec() !== 8'b0010_01_1_0) begin
            errors++;
            $display("FAIL reset_mid_regrant got %b want %b", obs_vec(), 8'b0010_01_1_0);
        end
        $display("reset_mid: grant=%b addr=%b%b", grant, address1, address0);
    endtask

    task automatic test_burst();
        int  on0, pulses;
        bit  still0;
        int  want_on0, want_pulses;
`ifdef RR_ARB_TIMEOUT_EN
        want_on0 = MAX_BURST; want_pulses = 2;
`else
        want_on0 = 21; want_pulses = 0;
`endif
        tick(1'b1, 4'b0000);
        tick(1'b0, 4'b0001);
        on0 = (grant == 4'b0001) ? 1 : 0;
        still0 = (on0 == 1);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            tick(1'b0, 4'b0011);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL burst cyc%0d got %b want %b", c, obs_vec(), exp_vec());
            end
            if (still0 && grant == 4'b0001) on0++;
            else still0 = 1'b0;
            if (preempted) pulses++;
        end
        checks++;
        if (on0 != want_on0 || pulses != want_pulses) begin
            errors++;
            $display("FAIL burst_len got on0=%0d pulses=%0d want on0=%0d pulses=%0d",
                     on0, pulses, want_on0, want_pulses);
        end
        $display("burst: cycles_on_0=%0d preempt_pulses=%0d", on0, pulses);
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic       rst;
        r = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
            rst = ($urandom_range(0, 63) == 0);
            tick(rst, r);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc%0d req=%b got %b want %b", c, r, obs_vec(), exp_vec());
            end
            checks++;
            if (!$onehot0(grant) || (valid && grant_index(grant) != int'({address1, address0}))) begin
                errors++;
                $display("FAIL invariant cyc%0d grant=%b addr=%b%b", c, grant, address1, address0);
            end
            $display("random cyc%0d: rst=%b req=%b grant=%b addr=%b%b valid=%b pre=%b",
                     c, rst, r, grant, address1, address0, valid, preempted);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_rotation();
        test_single();
        test_wrap();
        test_reset_mid();
        test_burst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
